// File: rtl/div_issue_ctrl.sv
// Issue sequencer in front of the iterative divider: latches one op per handshake,
// resolves divide-by-zero / signed overflow locally, and returns a tagged result.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a new op
// S_ISSUE | start pulse to the divider, operands already latched
// S_WAIT  | divider busy, waiting for div_done_i
// S_RESP  | result held on the response port until resp_ready_i
module div_issue_ctrl #(
    parameter int TAG_W     = 5,
    parameter bit FAST_PATH = 1'b1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             kill_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic             req_w_i,
    input  logic [63:0]      req_rs1_i,
    input  logic [63:0]      req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             div_request_o,
    output logic             div_kill_o,
    output logic             div_int32_o,
    output logic             div_signed_o,
    output logic [63:0]      div_dvnd_o,
    output logic [63:0]      div_dvsr_o,
    input  logic [63:0]      div_quo_i,
    input  logic [63:0]      div_rmd_i,
    input  logic             div_done_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [63:0]      resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_rem;
    logic               r_signed;
    logic               r_int32;
    logic [63:0]        r_rs1;
    logic [63:0]        r_rs2;
    logic [TAG_W-1:0]   r_tag;
    logic [63:0]        r_resp_data;

    logic               w_accept;
    logic               w_dvsr_zero;
    logic               w_ovf;
    logic               w_fast;
    logic [63:0]        w_fast_raw;
    logic [63:0]        w_div_raw;

    // W results are the low word sign-extended
    function automatic logic [63:0] sext_w(input logic [63:0] r, input logic w);
        return w ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

    assign w_accept    = (r_state == S_IDLE) && req_valid_i && !kill_i;
    assign w_dvsr_zero = req_w_i ? (req_rs2_i[31:0] == 32'h0) : (req_rs2_i == 64'h0);
    assign w_ovf       = !req_op_i[0] &&
                         (req_w_i ? (req_rs1_i[31:0] == 32'h8000_0000 && req_rs2_i[31:0] == 32'hFFFF_FFFF)
                                  : (req_rs1_i == 64'h8000_0000_0000_0000 && req_rs2_i == '1));
    assign w_fast      = FAST_PATH && (w_dvsr_zero || w_ovf);
    // divide-by-zero takes precedence; overflow returns dividend (DIV) or zero (REM)
    assign w_fast_raw  = w_dvsr_zero ? (req_op_i[1] ? req_rs1_i : '1)
                                     : (req_op_i[1] ? 64'h0 : req_rs1_i);
    assign w_div_raw   = r_rem ? div_rmd_i : div_quo_i;

    // state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // next-state logic; kill wins over everything, including a coincident done
    always_comb begin
        w_state_nxt = r_state;
        if (kill_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (req_valid_i) w_state_nxt = w_fast ? S_RESP : S_ISSUE;
                S_ISSUE: w_state_nxt = S_WAIT;
                S_WAIT:  if (div_done_i) w_state_nxt = S_RESP;
                S_RESP:  if (resp_ready_i) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // state-decoded outputs
    always_comb begin
        req_ready_o   = (r_state == S_IDLE);
        div_request_o = (r_state == S_ISSUE);
        resp_valid_o  = (r_state == S_RESP);
        busy_o        = (r_state != S_IDLE);
    end

    // operand latches change only on accept so the divider sees stable inputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rem       <= 1'b0;
            r_signed    <= 1'b0;
            r_int32     <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_tag       <= '0;
            r_resp_data <= '0;
        end else begin
            if (w_accept) begin
                r_rem    <= req_op_i[1];
                r_signed <= !req_op_i[0];
                r_int32  <= req_w_i;
                r_rs1    <= req_rs1_i;
                r_rs2    <= req_rs2_i;
                r_tag    <= req_tag_i;
                if (w_fast) r_resp_data <= sext_w(w_fast_raw, req_w_i);
            end
            if (r_state == S_WAIT && div_done_i && !kill_i)
                r_resp_data <= sext_w(w_div_raw, r_int32);
        end
    end

    assign div_kill_o   = kill_i;
    assign div_int32_o  = r_int32;
    assign div_signed_o = r_signed;
    assign div_dvnd_o   = r_rs1;
    assign div_dvsr_o   = r_rs2;
    assign resp_data_o  = r_resp_data;
    assign resp_tag_o   = r_tag;

endmodule
